// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seq_div_pkg;

  localparam int DW_DEF = 8;  // dividend / quotient width
  localparam int VW_DEF = 4;  // divisor / remainder width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the parent.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   prem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   prem_out,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic [VW:0] dvs_ext;

  // The incoming remainder is always below the divisor, so its top bit is
  // zero and dropping it on the shift loses nothing.
  always_comb begin
    shifted  = {prem_in[VW-1:0], bit_in};
    dvs_ext  = {1'b0, divisor};
    q_bit    = (shifted >= dvs_ext);
    prem_out = q_bit ? (shifted - dvs_ext) : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, one quotient bit per clock (restoring, MSB first).
// Latency: done DW edges after the accepting edge (one edge for divide-by-zero).
// Backpressure: start is ignored while busy; results hold until the next accept.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  state_t        state;
  logic [DW-1:0] dvd_sr;   // remaining dividend bits, MSB next
  logic [VW-1:0] dvs_q;    // divisor captured at accept
  logic [VW:0]   prem;     // partial remainder
  logic [DW-1:0] q_acc;    // quotient bits gathered so far
  logic [CW-1:0] cnt;      // steps completed in CALC

  logic [VW:0]   prem_next;
  logic          q_bit;

  div_step #(.VW(VW)) u_step (
    .prem_in  (prem),
    .bit_in   (dvd_sr[DW-1]),
    .divisor  (dvs_q),
    .prem_out (prem_next),
    .q_bit    (q_bit)
  );

  // Control FSM plus datapath; outputs only change at accept (div_by_zero) or entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_sr      <= '0;
      dvs_q       <= '0;
      prem        <= '0;
      q_acc       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state       <= ST_CALC;
              dvd_sr      <= dividend;
              dvs_q       <= divisor;
              prem        <= '0;
              q_acc       <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end

        ST_CALC: begin
          prem   <= prem_next;
          dvd_sr <= {dvd_sr[DW-2:0], 1'b0};
          q_acc  <= {q_acc[DW-2:0], q_bit};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            quotient  <= {q_acc[DW-2:0], q_bit};
            remainder <= prem_next[VW-1:0];
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
